// File: rtl/foc_frontend_dbg_pkg.sv
// Shared types and defaults for the FOC front-end debug path.
// Holds the deadlock-reporter state enum, the report record and a saturating increment.
package foc_frontend_dbg_pkg;

  localparam int unsigned AXIS_W_DEF    = 10;
  localparam int unsigned IDLE_W_DEF    = 5;
  localparam int unsigned TS_W_DEF      = 32;
  localparam int unsigned EVT_CNT_W     = 8;
  localparam int unsigned PERSIST_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_REPORT,
    ST_LATCHED
  } state_t;

  // One deadlock report as it would be pushed into a trace FIFO
  typedef struct packed {
    logic [AXIS_W_DEF-1:0] axis;
    logic [IDLE_W_DEF-1:0] idle;
    logic [TS_W_DEF-1:0]   timestamp;
    logic [EVT_CNT_W-1:0]  event_cnt;
  } report_rec_t;

  function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] v);
    return (v == '1) ? v : v + EVT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/foc_frontend_dbg_persist_cnt.sv
// Persistence counter: counts consecutive qualifying edges and flags the terminal count.
// at_threshold_c is true when the edge being sampled would be the PERSIST_CYCLES-th one.
module foc_frontend_dbg_persist_cnt
  import foc_frontend_dbg_pkg::*;
#(
  parameter int unsigned PERSIST_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic at_threshold_c
);

  localparam logic [PERSIST_CNT_W-1:0] TERMINAL = PERSIST_CNT_W'(PERSIST_CYCLES - 1);

  logic [PERSIST_CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + PERSIST_CNT_W'(1);
    end
  end

  assign at_threshold_c = (cnt == TERMINAL);

endmodule

// File: rtl/foc_frontend_hls_deadlock_reporter.sv
// Qualifies the deadlock monitor's block output and emits one timestamped report per event,
// then holds a sticky deadlock flag until software clears it.
module foc_frontend_hls_deadlock_reporter
  import foc_frontend_dbg_pkg::*;
#(
  parameter int unsigned AXIS_W         = AXIS_W_DEF,
  parameter int unsigned IDLE_W         = IDLE_W_DEF,
  parameter int unsigned PERSIST_CYCLES = 64,
  parameter int unsigned TS_W           = TS_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 block,
  input  logic [AXIS_W-1:0]    axis_block_sigs,
  input  logic [IDLE_W-1:0]    inst_idle_sigs,
  input  logic                 clear,
  output logic                 report_valid,
  input  logic                 report_ready,
  output logic [AXIS_W-1:0]    report_axis,
  output logic [IDLE_W-1:0]    report_idle,
  output logic [TS_W-1:0]      report_timestamp,
  output logic [EVT_CNT_W-1:0] report_event_cnt,
  output logic                 deadlock_flag
);

  state_t            state;
  logic [AXIS_W-1:0] acc;
  logic [TS_W-1:0]   ts;
  logic              at_threshold_c;
  logic              qualify_c;
  logic              capture_c;
  logic              cnt_enable_c;

  // Counting only happens while block holds in IDLE/PENDING; anything else restarts it
  assign qualify_c    = block && ((state == ST_IDLE) || (state == ST_PENDING));
  assign capture_c    = qualify_c && at_threshold_c;
  assign cnt_enable_c = qualify_c && !capture_c;

  foc_frontend_dbg_persist_cnt #(
    .PERSIST_CYCLES(PERSIST_CYCLES)
  ) u_persist_cnt (
    .clock          (clock),
    .reset          (reset),
    .clear          (!cnt_enable_c),
    .enable         (cnt_enable_c),
    .at_threshold_c (at_threshold_c)
  );

  // acc is kept at zero outside PENDING so acc | axis_block_sigs covers both capture paths
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_IDLE;
      acc              <= '0;
      ts               <= '0;
      report_valid     <= 1'b0;
      report_axis      <= '0;
      report_idle      <= '0;
      report_timestamp <= '0;
      report_event_cnt <= '0;
      deadlock_flag    <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      case (state)
        ST_IDLE, ST_PENDING: begin
          if (!block) begin
            acc   <= '0;
            state <= ST_IDLE;
          end else if (capture_c) begin
            report_axis      <= acc | axis_block_sigs;
            report_idle      <= inst_idle_sigs;
            report_timestamp <= ts;
            report_event_cnt <= sat_inc(report_event_cnt);
            report_valid     <= 1'b1;
            deadlock_flag    <= 1'b1;
            acc              <= '0;
            state            <= ST_REPORT;
          end else begin
            acc   <= acc | axis_block_sigs;
            state <= ST_PENDING;
          end
        end
        ST_REPORT: begin
          if (report_ready) begin
            report_valid <= 1'b0;
            state        <= ST_LATCHED;
          end
        end
        ST_LATCHED: begin
          if (clear) begin
            deadlock_flag <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_foc_frontend_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter: one instance with PERSIST_CYCLES=4, one with 1.
module tb_foc_frontend_hls_deadlock_reporter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  // PERSIST_CYCLES = 4 instance
  logic       rst4, blk4, clr4, rdy4, vld4, flag4;
  logic [9:0] axis4, raxis4;
  logic [4:0] idle4, ridle4;
  logic [31:0] rts4;
  logic [7:0] evt4;

  // PERSIST_CYCLES = 1 instance
  logic       rst1, blk1, clr1, rdy1, vld1, flag1;
  logic [9:0] axis1, raxis1;
  logic [4:0] idle1, ridle1;
  logic [31:0] rts1;
  logic [7:0] evt1;

  foc_frontend_hls_deadlock_reporter #(
    .AXIS_W(10), .IDLE_W(5), .PERSIST_CYCLES(4), .TS_W(32)
  ) u_dut4 (
    .clock(clock), .reset(rst4), .block(blk4), .axis_block_sigs(axis4),
    .inst_idle_sigs(idle4), .clear(clr4), .report_valid(vld4), .report_ready(rdy4),
    .report_axis(raxis4), .report_idle(ridle4), .report_timestamp(rts4),
    .report_event_cnt(evt4), .deadlock_flag(flag4)
  );

  foc_frontend_hls_deadlock_reporter #(
    .AXIS_W(10), .IDLE_W(5), .PERSIST_CYCLES(1), .TS_W(32)
  ) u_dut1 (
    .clock(clock), .reset(rst1), .block(blk1), .axis_block_sigs(axis1),
    .inst_idle_sigs(idle1), .clear(clr1), .report_valid(vld1), .report_ready(rdy1),
    .report_axis(raxis1), .report_idle(ridle1), .report_timestamp(rts1),
    .report_event_cnt(evt1), .deadlock_flag(flag1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst4 = 1'b1; blk4 = 1'b0; clr4 = 1'b0; rdy4 = 1'b1; axis4 = '0; idle4 = '0;
    rst1 = 1'b1; blk1 = 1'b0; clr1 = 1'b0; rdy1 = 1'b1; axis1 = '0; idle1 = '0;
    tick(); tick();

    // Reset state
    chk("rst_valid", 64'(vld4), 64'd0);
    chk("rst_flag",  64'(flag4), 64'd0);
    chk("rst_evt",   64'(evt4), 64'd0);
    chk("rst_ts",    64'(rts4), 64'd0);
    chk("rst_axis",  64'(raxis4), 64'd0);

    // Basic qualification: 4 edges, axis bits OR'ed over the window
    rst4 = 1'b0;
    blk4 = 1'b1; axis4 = 10'h000; tick();
    axis4 = 10'h001; tick();
    axis4 = 10'h000; tick();
    chk("tp1_not_yet", 64'(vld4), 64'd0);
    axis4 = 10'h080; idle4 = 5'h15; tick();
    chk("tp1_valid", 64'(vld4), 64'd1);
    chk("tp1_axis",  64'(raxis4), 64'h081);
    chk("tp1_idle",  64'(ridle4), 64'h15);
    chk("tp1_ts",    64'(rts4), 64'd3);
    chk("tp1_evt",   64'(evt4), 64'd1);
    chk("tp1_flag",  64'(flag4), 64'd1);
    blk4 = 1'b0; axis4 = '0; idle4 = '0; tick();
    chk("tp1_hs_valid", 64'(vld4), 64'd0);
    chk("tp1_hs_flag",  64'(flag4), 64'd1);
    chk("tp1_hs_axis",  64'(raxis4), 64'h081);

    // Release, then an interrupted run followed by a full run
    clr4 = 1'b1; tick(); clr4 = 1'b0;
    chk("tp2_cleared", 64'(flag4), 64'd0);
    blk4 = 1'b1; axis4 = 10'h200; tick(); tick(); tick();
    blk4 = 1'b0; axis4 = 10'h000; tick();
    chk("tp2_no_report", 64'(vld4), 64'd0);
    rdy4 = 1'b0;
    blk4 = 1'b1; tick();
    axis4 = 10'h004; tick();
    axis4 = 10'h000; tick();
    chk("tp2_not_yet", 64'(vld4), 64'd0);
    tick();
    chk("tp2_valid", 64'(vld4), 64'd1);
    chk("tp2_axis",  64'(raxis4), 64'h004);
    chk("tp2_ts",    64'(rts4), 64'd13);
    chk("tp2_evt",   64'(evt4), 64'd2);

    // Backpressure: everything holds while block toggles and clear pulses
    for (int i = 0; i < 10; i++) begin
      blk4 = i[0]; clr4 = i[1]; axis4 = 10'h3FF;
      tick();
      chk("tp3_valid", 64'(vld4), 64'd1);
      chk("tp3_axis",  64'(raxis4), 64'h004);
      chk("tp3_ts",    64'(rts4), 64'd13);
      chk("tp3_flag",  64'(flag4), 64'd1);
    end
    clr4 = 1'b0; blk4 = 1'b1; axis4 = '0; rdy4 = 1'b1; tick();
    chk("tp3_hs_valid", 64'(vld4), 64'd0);
    chk("tp3_hs_flag",  64'(flag4), 64'd1);
    chk("tp3_hs_evt",   64'(evt4), 64'd2);

    // Clear with block held high restarts qualification from zero
    tick(); tick();
    chk("tp4_latched_no_report", 64'(vld4), 64'd0);
    clr4 = 1'b1; tick(); clr4 = 1'b0;
    chk("tp4_flag_fall", 64'(flag4), 64'd0);
    tick(); tick(); tick();
    chk("tp4_not_yet", 64'(vld4), 64'd0);
    rdy4 = 1'b0; tick();
    chk("tp4_valid", 64'(vld4), 64'd1);
    chk("tp4_evt",   64'(evt4), 64'd3);
    chk("tp4_ts",    64'(rts4), 64'd31);
    chk("tp4_flag",  64'(flag4), 64'd1);

    // Reset while a report is pending
    rst4 = 1'b1; tick();
    chk("tp6_valid", 64'(vld4), 64'd0);
    chk("tp6_flag",  64'(flag4), 64'd0);
    chk("tp6_evt",   64'(evt4), 64'd0);
    chk("tp6_ts",    64'(rts4), 64'd0);
    rst4 = 1'b0; blk4 = 1'b0; tick();
    tick();
    chk("tp6_idle_no_report", 64'(vld4), 64'd0);

    // PERSIST_CYCLES = 1: single-edge pulses, event count saturates
    rst1 = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      blk1 = 1'b1; axis1 = 10'h3FF; idle1 = 5'h0A; tick();
      if (i == 1) begin
        chk("tp5_valid",  64'(vld1), 64'd1);
        chk("tp5_axis",   64'(raxis1), 64'h3FF);
        chk("tp5_idle",   64'(ridle1), 64'h0A);
        chk("tp5_ts",     64'(rts1), 64'd0);
        chk("tp5_evt1",   64'(evt1), 64'd1);
      end
      if (i == 255) chk("tp5_evt255", 64'(evt1), 64'd255);
      blk1 = 1'b0; axis1 = '0; tick();
      clr1 = 1'b1; tick(); clr1 = 1'b0;
    end
    chk("tp5_evt_sat", 64'(evt1), 64'd255);
    chk("tp5_flag",    64'(flag1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
